// File: rtl/ex_muldiv.sv
// EX-stage HI/LO multiply/divide unit: single-cycle mult/multu, radix-2 restoring div/divu.
// Optional feature: define MULDIV_DIVZERO_FLAG_EN to add the div_zero output and short-circuit divide-by-zero.
module ex_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             cpu_clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef MULDIV_DIVZERO_FLAG_EN
    output logic             div_zero,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_FIX
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH-1:0]   rem_q, quo_q, dvsr_q;
    logic               q_neg_q, r_neg_q;
    logic               done_q;
`ifdef MULDIV_DIVZERO_FLAG_EN
    logic               div_zero_q;
`endif

    logic               is_mul, is_div, is_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] mul_a, mul_b, prod_d;
    logic [WIDTH:0]     rem_shift, diff;
    logic [WIDTH-1:0]   rem_d, quo_d;

    // Operand decode and the single-cycle product.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        is_mul    = (func == FUNC_MULT) || (func == FUNC_MULTU);
        is_div    = (func == FUNC_DIV)  || (func == FUNC_DIVU);
        is_signed = (func == FUNC_MULT) || (func == FUNC_DIV);
        a_neg     = is_signed & op_a[WIDTH-1];
        b_neg     = is_signed & op_b[WIDTH-1];
        abs_a     = a_neg ? (~op_a + 1'b1) : op_a;
        abs_b     = b_neg ? (~op_b + 1'b1) : op_b;
        // Low 2*WIDTH bits of the extended product equal the true signed/unsigned product.
        mul_a     = {{WIDTH{a_neg}}, op_a};
        mul_b     = {{WIDTH{b_neg}}, op_b};
        prod_d    = mul_a * mul_b;
    end

    // One restoring-division step: shift the next dividend bit in, subtract if it fits.
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, dvsr_q};
        rem_d     = rem_shift[WIDTH-1:0];
        quo_d     = {quo_q[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            done_q     <= 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            done_q     <= 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
            div_zero_q <= 1'b0;
`endif
            if (flush) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && is_mul) begin
                            {hi_q, lo_q} <= prod_d;
                            done_q       <= 1'b1;
                        end else if (start && is_div) begin
`ifdef MULDIV_DIVZERO_FLAG_EN
                            if (op_b == '0) begin
                                done_q     <= 1'b1;
                                div_zero_q <= 1'b1;
                            end else begin
`endif
                                rem_q   <= '0;
                                quo_q   <= abs_a;
                                dvsr_q  <= abs_b;
                                q_neg_q <= a_neg ^ b_neg;
                                r_neg_q <= a_neg;
                                cnt_q   <= '0;
                                state_q <= S_DIV;
`ifdef MULDIV_DIVZERO_FLAG_EN
                            end
`endif
                        end else if (!start) begin
                            if (mthi) hi_q <= op_a;
                            if (mtlo) lo_q <= op_a;
                        end
                    end
                    S_DIV: begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= S_FIX;
                    end
                    S_FIX: begin
                        lo_q    <= q_neg_q ? (~quo_q + 1'b1) : quo_q;
                        hi_q    <= r_neg_q ? (~rem_q + 1'b1) : rem_q;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MULDIV_DIVZERO_FLAG_EN
    assign div_zero = div_zero_q;
`endif

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv; honours MULDIV_DIVZERO_FLAG_EN the same way as the RTL.
module tb_ex_muldiv;

    logic        cpu_clk = 1'b0;
    logic        reset, flush, start, mthi, mtlo;
    logic [5:0]  func;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] hi, lo;
`ifdef MULDIV_DIVZERO_FLAG_EN
    logic        div_zero;
`endif

    int n_cmp = 0;
    int n_err = 0;

    ex_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
        .cpu_clk (cpu_clk),
        .reset   (reset),
        .flush   (flush),
        .start   (start),
        .func    (func),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .op_a    (op_a),
        .op_b    (op_b),
`ifdef MULDIV_DIVZERO_FLAG_EN
        .div_zero(div_zero),
`endif
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic tick;
        @(posedge cpu_clk);
        #1;
    endtask

    // Counts cycles with busy high, bounded so a stuck DUT cannot hang the run.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; func = f; op_a = a; op_b = b;
        tick();
        start = 1'b0; func = 6'h00;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        func = 6'h00; op_a = '0; op_b = '0;
        tick(); tick();
        reset = 1'b0;
        n_cmp++;
        if ({hi, lo, busy, done} !== 66'd0) begin
            n_err++; $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b want all 0", hi, lo, busy, done);
        end
    endtask

    task automatic test_mult;
        issue(6'h18, 32'hFFFFFFFD, 32'd5);
        n_cmp++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1 || done !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL mult: hi=%h lo=%h done=%b busy=%b want ffffffff fffffff1 1 0", hi, lo, done, busy);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++; $display("FAIL mult_done_pulse: done=%b want 0", done);
        end
        issue(6'h19, 32'hFFFFFFFF, 32'd2);
        n_cmp++;
        if (hi !== 32'd1 || lo !== 32'hFFFFFFFE || done !== 1'b1) begin
            n_err++; $display("FAIL multu: hi=%h lo=%h done=%b want 00000001 fffffffe 1", hi, lo, done);
        end
        tick();
    endtask

    task automatic test_divu;
        int n;
        issue(6'h1B, 32'd100, 32'd7);
        wait_idle(n);
        n_cmp++;
        if (n != 33) begin
            n_err++; $display("FAIL divu_busy_len: got %0d cycles want 33", n);
        end
        n_cmp++;
        if (lo !== 32'd14 || hi !== 32'd2 || done !== 1'b1) begin
            n_err++; $display("FAIL divu_result: lo=%h hi=%h done=%b want 0000000e 00000002 1", lo, hi, done);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++; $display("FAIL divu_done_pulse: done=%b want 0", done);
        end
    endtask

    task automatic test_div_signed;
        int n;
        issue(6'h1A, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        n_cmp++;
        if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF || n != 33) begin
            n_err++; $display("FAIL div_neg7_2: lo=%h hi=%h cycles=%0d want fffffffd ffffffff 33", lo, hi, n);
        end
        tick();
        issue(6'h1A, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        n_cmp++;
        if (lo !== 32'h80000000 || hi !== 32'd0) begin
            n_err++; $display("FAIL div_corner: lo=%h hi=%h want 80000000 00000000", lo, hi);
        end
        tick();
    endtask

    task automatic test_mthi_mtlo;
        mtlo = 1'b1; op_a = 32'd5; tick(); mtlo = 1'b0;
        mthi = 1'b1; op_a = 32'd9; tick(); mthi = 1'b0;
        n_cmp++;
        if (lo !== 32'd5 || hi !== 32'd9 || done !== 1'b0) begin
            n_err++; $display("FAIL mtlo_mthi: lo=%h hi=%h done=%b want 5 9 0", lo, hi, done);
        end
        mthi = 1'b1; mtlo = 1'b1; op_a = 32'h00001234; tick();
        mthi = 1'b0; mtlo = 1'b0;
        n_cmp++;
        if (lo !== 32'h00001234 || hi !== 32'h00001234) begin
            n_err++; $display("FAIL mt_both: lo=%h hi=%h want 00001234 00001234", lo, hi);
        end
        // start with an unused func code still blocks the move.
        start = 1'b1; func = 6'h20; mthi = 1'b1; op_a = 32'd77; tick();
        start = 1'b0; func = 6'h00; mthi = 1'b0;
        n_cmp++;
        if (hi !== 32'h00001234 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL mthi_start_wins: hi=%h busy=%b done=%b want 00001234 0 0", hi, busy, done);
        end
    endtask

    task automatic test_mthi_busy;
        int n;
        issue(6'h1B, 32'd100, 32'd7);
        tick(); tick();
        mthi = 1'b1; op_a = 32'hDEADBEEF; tick(); mthi = 1'b0;
        wait_idle(n);
        n_cmp++;
        if (hi !== 32'd2 || lo !== 32'd14 || n != 30) begin
            n_err++; $display("FAIL mthi_while_busy: hi=%h lo=%h rest=%0d want 2 e 30", hi, lo, n);
        end
        tick();
    endtask

    task automatic test_flush;
        mthi = 1'b1; mtlo = 1'b1; op_a = 32'hA5A5A5A5; tick();
        mthi = 1'b0; mtlo = 1'b0;
        issue(6'h1B, 32'd100, 32'd7);
        repeat (9) tick();
        flush = 1'b1; tick(); flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'hA5A5A5A5 || lo !== 32'hA5A5A5A5) begin
            n_err++; $display("FAIL flush_abort: busy=%b done=%b hi=%h lo=%h want 0 0 a5a5a5a5 a5a5a5a5", busy, done, hi, lo);
        end
        repeat (30) tick();
        n_cmp++;
        if (done !== 1'b0 || hi !== 32'hA5A5A5A5) begin
            n_err++; $display("FAIL flush_no_late_done: done=%b hi=%h want 0 a5a5a5a5", done, hi);
        end
    endtask

    task automatic test_reset_abort;
        mthi = 1'b1; mtlo = 1'b1; op_a = 32'hA5A5A5A5; tick();
        mthi = 1'b0; mtlo = 1'b0;
        issue(6'h1B, 32'd100, 32'd7);
        repeat (5) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++; $display("FAIL reset_abort: busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
        end
    endtask

    task automatic test_divzero;
        int n;
        mthi = 1'b1; mtlo = 1'b1; op_a = 32'h0BADF00D; tick();
        mthi = 1'b0; mtlo = 1'b0;
        issue(6'h1B, 32'd9, 32'd0);
`ifdef MULDIV_DIVZERO_FLAG_EN
        n_cmp++;
        if (div_zero !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || hi !== 32'h0BADF00D || lo !== 32'h0BADF00D) begin
            n_err++; $display("FAIL divu_zero_flag: dz=%b done=%b busy=%b hi=%h lo=%h want 1 1 0 0badf00d 0badf00d", div_zero, done, busy, hi, lo);
        end
        tick();
        n_cmp++;
        if (div_zero !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL divzero_pulse: dz=%b done=%b want 0 0", div_zero, done);
        end
        issue(6'h1A, 32'hFFFFFFF7, 32'd0);
        n_cmp++;
        if (div_zero !== 1'b1 || busy !== 1'b0 || hi !== 32'h0BADF00D) begin
            n_err++; $display("FAIL div_zero_flag: dz=%b busy=%b hi=%h want 1 0 0badf00d", div_zero, busy, hi);
        end
        n = 0;
`else
        wait_idle(n);
        n_cmp++;
        if (n != 33 || lo !== 32'hFFFFFFFF || hi !== 32'd9) begin
            n_err++; $display("FAIL divu_zero: cycles=%0d lo=%h hi=%h want 33 ffffffff 00000009", n, lo, hi);
        end
        tick();
        issue(6'h1A, 32'hFFFFFFF7, 32'd0);
        wait_idle(n);
        n_cmp++;
        if (lo !== 32'd1 || hi !== 32'hFFFFFFF7) begin
            n_err++; $display("FAIL div_zero_signed: lo=%h hi=%h want 00000001 fffffff7", lo, hi);
        end
`endif
        tick();
    endtask

    task automatic test_back_to_back;
        int n;
        issue(6'h1B, 32'hFFFFFFFF, 32'd1);
        wait_idle(n);
        issue(6'h18, 32'h00010000, 32'h00010000);
        n_cmp++;
        if (hi !== 32'd1 || lo !== 32'd0 || done !== 1'b1) begin
            n_err++; $display("FAIL b2b_mult: hi=%h lo=%h done=%b want 1 0 1", hi, lo, done);
        end
        issue(6'h1A, 32'd7, 32'hFFFFFFFE);
        wait_idle(n);
        n_cmp++;
        if (lo !== 32'hFFFFFFFD || hi !== 32'd1 || n != 33) begin
            n_err++; $display("FAIL b2b_div_7_neg2: lo=%h hi=%h cycles=%0d want fffffffd 1 33", lo, hi, n);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_mult();
        test_divu();
        test_div_signed();
        test_mthi_mtlo();
        test_mthi_busy();
        test_flush();
        test_reset_abort();
        test_divzero();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
